// File: rtl/piso_ser_if.sv
// Parallel-in / serial-out handshake bundle: word load on one side, bit stream on the other.
interface piso_ser_if #(
  parameter int DATA_W = 8
);
  logic              parallel_valid_i;
  logic [DATA_W-1:0] parallel_i;
  logic              parallel_ready_o;
  logic              serial_o;
  logic              valid_o;
  logic              serial_ready_i;
  logic              last_o;
  logic              empty_o;

  // master: word producer and bit consumer; slave: the serializer itself
  modport master (
    output parallel_valid_i, parallel_i, serial_ready_i,
    input  parallel_ready_o, serial_o, valid_o, last_o, empty_o
  );

  modport slave (
    input  parallel_valid_i, parallel_i, serial_ready_i,
    output parallel_ready_o, serial_o, valid_o, last_o, empty_o
  );
endinterface

// File: rtl/piso_ser.sv
// Parallel-to-serial shifter with valid/ready on both sides; a new word may be
// loaded in the same cycle the final bit of the current word is consumed.
module piso_ser #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  piso_ser_if.slave    bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_next;

  logic valid;
  logic last;
  logic consume;
  logic ready;
  logic load;

  assign valid   = (state_q == SHIFT);
  assign last    = valid && (cnt_q == CNT_W'(1));
  assign consume = valid && bus.serial_ready_i;
  // Ready reaches back through serial_ready_i so the next word loads with no bubble
  assign ready   = (state_q == IDLE) || (consume && last);
  assign load    = bus.parallel_valid_i && ready;

  always_comb begin
    shift_next = '0;
    if (MSB_FIRST) begin
      shift_next = {shift_q[DATA_W-2:0], 1'b0};
    end else begin
      shift_next = {1'b0, shift_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      shift_q <= bus.parallel_i;
      cnt_q   <= CNT_W'(DATA_W);
    end else if (consume) begin
      if (last) begin
        state_q <= IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        shift_q <= shift_next;
        cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.parallel_ready_o = ready;
  assign bus.valid_o          = valid;
  assign bus.empty_o          = !valid;
  assign bus.last_o           = last;
  assign bus.serial_o         = valid && (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
endmodule

// File: tb/tb_piso_ser.sv
// Bench for piso_ser: three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit
// MSB-first) checked cycle by cycle against a queue-of-bits reference model.
module tb_piso_ser;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        pv_r = 1'b0;
  logic [31:0] pd_r = '0;
  logic        sr_r = 1'b0;

  piso_ser_if #(.DATA_W(4)) if0 ();
  piso_ser_if #(.DATA_W(4)) if1 ();
  piso_ser_if #(.DATA_W(8)) if2 ();

  piso_ser #(.DATA_W(4), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  piso_ser #(.DATA_W(4), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  piso_ser #(.DATA_W(8), .MSB_FIRST(1'b1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  assign if0.parallel_valid_i = (sel == 0) && pv_r;
  assign if0.serial_ready_i   = (sel == 0) && sr_r;
  assign if0.parallel_i       = pd_r[3:0];
  assign if1.parallel_valid_i = (sel == 1) && pv_r;
  assign if1.serial_ready_i   = (sel == 1) && sr_r;
  assign if1.parallel_i       = pd_r[3:0];
  assign if2.parallel_valid_i = (sel == 2) && pv_r;
  assign if2.serial_ready_i   = (sel == 2) && sr_r;
  assign if2.parallel_i       = pd_r[7:0];

  logic so, vo, lo, eo, pr;
  always_comb begin
    so = 1'b0; vo = 1'b0; lo = 1'b0; eo = 1'b0; pr = 1'b0;
    case (sel)
      0: begin so = if0.serial_o; vo = if0.valid_o; lo = if0.last_o; eo = if0.empty_o; pr = if0.parallel_ready_o; end
      1: begin so = if1.serial_o; vo = if1.valid_o; lo = if1.last_o; eo = if1.empty_o; pr = if1.parallel_ready_o; end
      default: begin so = if2.serial_o; vo = if2.valid_o; lo = if2.last_o; eo = if2.empty_o; pr = if2.parallel_ready_o; end
    endcase
  end

  typedef struct packed {
    logic b;
    logic last;
  } sbit_t;

  sbit_t q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    n_bits   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h t=%0t", tag, sel, obs, exp, $time);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 2) ? 8 : 4;
  endfunction

  // A loaded word becomes an ordered list of bits, the final one flagged as last
  task automatic push_word(input logic [31:0] d);
    int  w;
    bit  msb;
    sbit_t e;
    w   = width_of(sel);
    msb = (sel != 1);
    for (int i = 0; i < w; i++) begin
      e.b    = msb ? d[w-1-i] : d[i];
      e.last = (i == w - 1);
      q.push_back(e);
    end
  endtask

  // One clock of traffic: drive, check the cycle's outputs, then advance the model
  task automatic cyc(input logic pv, input logic [31:0] d, input logic sr);
    logic e_valid, e_bit, e_last, e_cons, e_ready;
    pv_r = pv; pd_r = d; sr_r = sr;
    #1;
    e_valid = (q.size() > 0);
    e_bit   = e_valid ? q[0].b : 1'b0;
    e_last  = e_valid ? q[0].last : 1'b0;
    e_cons  = e_valid && sr;
    e_ready = !e_valid || (e_cons && e_last);
    chk("valid", 32'(vo), 32'(e_valid));
    chk("empty", 32'(eo), 32'(!e_valid));
    chk("serial", 32'(so), 32'(e_bit));
    chk("last", 32'(lo), 32'(e_last));
    chk("ready", 32'(pr), 32'(e_ready));
    $display("t=%0t dut=%0d pv=%0b d=%0h sr=%0b -> valid=%0b bit=%0b last=%0b ready=%0b",
             $time, sel, pv, d, sr, vo, so, lo, pr);
    @(posedge clk);
    if (e_cons) begin
      void'(q.pop_front());
      n_bits++;
    end
    if (pv && e_ready) push_word(d);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cyc(1'b0, 32'h0, 1'b1);
    chk("drain_timeout", 32'(q.size()), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_serial"}, 32'(so), 32'd0);
    chk({tag, "_valid"}, 32'(vo), 32'd0);
    chk({tag, "_last"}, 32'(lo), 32'd0);
    chk({tag, "_empty"}, 32'(eo), 32'd1);
    chk({tag, "_ready"}, 32'(pr), 32'd1);
  endtask

  initial begin
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk_reset_outputs("reset_state");
    end
    sel = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 4-bit MSB-first: 1011 streams 1,0,1,1 then idles
    cyc(1'b1, 32'hB, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'hF, 1'b1);

    // Back-to-back A then 5 with valid held high; next load rides the last bit
    cyc(1'b1, 32'hA, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h5, 1'b1);
    cyc(1'b1, 32'h5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
    chk("b2b_bits", 32'(n_bits), 32'd11);
    drain();

    // Backpressure: stall three cycles after the first bit
    cyc(1'b1, 32'hC, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h7, 1'b0);
    drain();

    // Reset mid-word after two bits are consumed
    cyc(1'b1, 32'h9, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    pv_r = 1'b0; sr_r = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    q.delete();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 32'h3, 1'b1);
    drain();

    // 4-bit LSB-first: 1011 streams 1,1,0,1
    sel = 1;
    cyc(1'b1, 32'hB, 1'b1);
    drain();

    // 8-bit: 0x81 streams 1,0,0,0,0,0,0,1
    sel = 2;
    cyc(1'b1, 32'h81, 1'b1);
    drain();

    // Random traffic on each instance
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 80; i++)
        cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
